arbitro_memoria_dados: RTL
==========================

ARBITRO_MEMORIA_DADOS -- requirements
Module: arbitro_memoria_dados

Interface
REQ-001 The block SHALL have parameter PROFUNDIDADE, default 64, data-memory depth in 32-bit words.
REQ-002 The block SHALL have parameter LARGURA_END, default 6, word-index width; it SHALL equal clog2(PROFUNDIDADE).
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have, for n in {0,1}, ports reqn in 1 (request), wen in 1 (1=store, 0=load), meion in 1 (1=halfword, 0=word), endn in 32 (byte address), dadon in 32 (store data).
REQ-006 The block SHALL have, for n in {0,1}, ports gntn out 1 (grant pulse), validon out 1 (completion pulse), lidon out 32 (load result), erron out 1 (out-of-range flag, valid with validon).
REQ-007 The block SHALL have memory-side ports mem_en out 1, mem_we out 1, mem_end out LARGURA_END, mem_dado out 32, mem_mascara out 2 (bit0=bits15:0, bit1=bits31:16), mem_lido in 32 (synchronous read, one-cycle latency).

Function
REQ-008 FSM states SHALL be OCIOSO, CONCEDE, RESPONDE.
REQ-009 OCIOSO: if req0 or req1, go to CONCEDE with the selected requester latched; else stay.
REQ-010 CONCEDE (one cycle): gntn=1 for the selected port; mem_en=1; mem_end=endn[LARGURA_END+1:2]; mem_we=wen; mem_dado=dadon; mem_mascara=2'b01 if meion else 2'b11; next state RESPONDE.
REQ-011 RESPONDE (one cycle): validon=1 for the served port; loads return lidon = mem_lido if word, {16{mem_lido[15]},mem_lido[15:0]} if halfword; stores return lidon=0.
REQ-012 From RESPONDE the FSM SHALL go to CONCEDE directly if any req is high (back-to-back, 2 cycles per transaction), else OCIOSO.
REQ-013 Latency SHALL be: req sampled high in OCIOSO -> gnt next cycle -> valido the cycle after.
REQ-014 Requesters SHALL hold req/we/meio/end/dado stable until gnt; a req still high in the cycle of its valido is a new request.
REQ-015 endn >= 4*PROFUNDIDADE SHALL suppress mem_en in CONCEDE and return erron=1, lidon=0 in RESPONDE; erron=0 otherwise.
REQ-016 endn[1:0] SHALL be ignored (word index only); halfword accesses always use bits 15:0.
REQ-017 gnt0 and gnt1 SHALL never be high in the same cycle; same for valido0/valido1.
REQ-018 All outputs SHALL be 0 in every cycle where not driven per REQ-010/011.

Reset
REQ-019 rst low SHALL immediately force state OCIOSO, all outputs 0, round-robin pointer to "last served = port 1", dropping any in-flight transaction without a memory write.
REQ-020 First rising edge after rst high SHALL behave as OCIOSO.

Configuration
REQ-021 With ARBITRO_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not served last; pointer updates in CONCEDE.
REQ-022 Without ARBITRO_ROUND_ROBIN_EN, port 0 SHALL always win simultaneous requests (port 1 may starve); pointer logic absent.

Structure
REQ-023 FSM state encoding, mask constants and the halfword/word code SHALL live in shared package pacote_memoria.
REQ-024 Selection logic SHALL be one sub-module seletor_prioridade (inputs req0, req1, pointer; output winner).

Verification
REQ-025 Reset then req0=1, we0=1, meio0=0, end0=0x08, dado0=0xCAFEBABE -> gnt0 cycle 1 with mem_we=1, mem_end=2, mem_mascara=11; valido0 cycle 2, erro0=0.
REQ-026 Word 2 = 0x0000F234, req1 load halfword end1=0x08 -> valido1 with lido1=0xFFFFF234; word load -> 0x0000F234.
REQ-027 req0 and req1 held high for 8 cycles with round-robin -> grants 0,1,0,1 at 2-cycle spacing; without macro -> all four to port 0.
REQ-028 req0 load end0=0x100 (PROFUNDIDADE=64) -> mem_en stays 0, valido0 with erro0=1, lido0=0.
REQ-029 rst driven low mid-cycle during CONCEDE of a store -> gnt0/mem_en drop at once, no write, word unchanged; after release next req served normally.
REQ-030 Every cycle of every test: gnt0&gnt1=0, valido0&valido1=0, mem_en only in CONCEDE.

Source files
------------

// File: rtl/pacote_memoria.sv
// ---------------------------------------------------------------------------
// pacote_memoria
//
// Shared definitions for the data-memory arbiter:
//   estado_t        - arbiter FSM states (OCIOSO, CONCEDE, RESPONDE)
//   tamanho_t       - access-size code carried on the meio inputs
//   MASCARA_*       - halfword-lane write masks driven on mem_mascara
//                     (bit0 = bits 15:0, bit1 = bits 31:16)
//   mascara_de()    - access size -> lane mask
//   estende_meia()  - sign-extends the low halfword of a memory word
// ---------------------------------------------------------------------------
package pacote_memoria;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONCEDE  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    typedef enum logic {
        TAM_PALAVRA = 1'b0,
        TAM_MEIA    = 1'b1
    } tamanho_t;

    localparam logic [1:0] MASCARA_PALAVRA = 2'b11;
    localparam logic [1:0] MASCARA_MEIA    = 2'b01;

    // Halfword accesses always live in the low lane, whatever endn[1:0] says.
    function automatic logic [1:0] mascara_de(input tamanho_t tamanho);
        return (tamanho == TAM_MEIA) ? MASCARA_MEIA : MASCARA_PALAVRA;
    endfunction

    function automatic logic [31:0] estende_meia(input logic [31:0] palavra);
        return {{16{palavra[15]}}, palavra[15:0]};
    endfunction

endpackage

// File: rtl/seletor_prioridade.sv
// ---------------------------------------------------------------------------
// seletor_prioridade
//
// Picks which of the two requesters is served next.
//   req0, req1  in  pending requests
//   ultimo      in  port served last (0 or 1)
//   vencedor    out selected port (only meaningful when req0 | req1)
//
// A lone request always wins. On a tie the port that was NOT served last
// wins, so holding ultimo at 1 turns this into fixed priority for port 0.
// ---------------------------------------------------------------------------
module seletor_prioridade (
    input  logic req0,
    input  logic req1,
    input  logic ultimo,
    output logic vencedor
);

    always_comb begin
        vencedor = 1'b0;
        if (req0 && req1) begin
            vencedor = ~ultimo;
        end else if (req1) begin
            vencedor = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// ---------------------------------------------------------------------------
// arbitro_memoria_dados
//
// Two-port arbiter in front of a single-port synchronous data memory
// (PROFUNDIDADE 32-bit words, one-cycle read latency). Each transaction
// takes two cycles: CONCEDE drives the memory and pulses gntn, RESPONDE
// pulses validon with the load result and the out-of-range flag.
//
// Parameters
//   PROFUNDIDADE  memory depth in words (default 64)
//   LARGURA_END   word-index width, clog2(PROFUNDIDADE) (default 6)
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   reqn, wen, meion         request, 1=store/0=load, 1=halfword/0=word
//   endn, dadon              byte address, store data
//   gntn, validon            grant pulse, completion pulse
//   lidon, erron             load result, out-of-range flag (with validon)
//   mem_en, mem_we           memory enable / write enable
//   mem_end, mem_dado        word index, write data
//   mem_mascara              lane mask (bit0 = 15:0, bit1 = 31:16)
//   mem_lido                 memory read data (one cycle after mem_en)
//
// Configuration
//   ARBITRO_ROUND_ROBIN_EN   defined: ties go to the port not served last.
//                            undefined: port 0 always wins ties.
// ---------------------------------------------------------------------------
module arbitro_memoria_dados
    import pacote_memoria::*;
#(
    parameter int PROFUNDIDADE = 64,
    parameter int LARGURA_END  = 6
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0,
    input  logic                   we0,
    input  logic                   meio0,
    input  logic [31:0]            end0,
    input  logic [31:0]            dado0,

    input  logic                   req1,
    input  logic                   we1,
    input  logic                   meio1,
    input  logic [31:0]            end1,
    input  logic [31:0]            dado1,

    output logic                   gnt0,
    output logic                   valido0,
    output logic [31:0]            lido0,
    output logic                   erro0,

    output logic                   gnt1,
    output logic                   valido1,
    output logic [31:0]            lido1,
    output logic                   erro1,

    output logic                   mem_en,
    output logic                   mem_we,
    output logic [LARGURA_END-1:0] mem_end,
    output logic [31:0]            mem_dado,
    output logic [1:0]             mem_mascara,
    input  logic [31:0]            mem_lido
);

    localparam logic [31:0] LIMITE_BYTES = 32'(4 * PROFUNDIDADE);

    estado_t     estado;
    estado_t     proximo;

    logic        sel_q;
    logic        we_q;
    logic        meio_q;
    logic        erro_q;

    logic        ultimo;
    logic        vencedor;
    logic        ha_pedido;

    logic        sel_we;
    logic        sel_meio;
    logic [31:0] sel_end;
    logic [31:0] sel_dado;
    logic        sel_fora;
    logic [31:0] resultado;

    assign ha_pedido = req0 | req1;

    // Requesters hold their fields until gnt, so the CONCEDE cycle can read
    // them straight from the selected port.
    assign sel_we   = sel_q ? we1   : we0;
    assign sel_meio = sel_q ? meio1 : meio0;
    assign sel_end  = sel_q ? end1  : end0;
    assign sel_dado = sel_q ? dado1 : dado0;
    assign sel_fora = (sel_end >= LIMITE_BYTES);

    seletor_prioridade u_seletor (
        .req0     (req0),
        .req1     (req1),
        .ultimo   (ultimo),
        .vencedor (vencedor)
    );

`ifdef ARBITRO_ROUND_ROBIN_EN
    // Reset value "port 1 served last" makes port 0 win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ultimo <= 1'b1;
        end else if (estado == CONCEDE) begin
            ultimo <= sel_q;
        end
    end
`else
    // Fixed priority: pretending port 1 was always served last hands every
    // tie to port 0.
    assign ultimo = 1'b1;
`endif

    // The requester is chosen on the edge that enters CONCEDE; the access
    // attributes are captured on the edge that leaves it, because the
    // requester is free to change them once gnt has been seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado <= OCIOSO;
            sel_q  <= 1'b0;
            we_q   <= 1'b0;
            meio_q <= 1'b0;
            erro_q <= 1'b0;
        end else begin
            estado <= proximo;
            if ((estado == OCIOSO || estado == RESPONDE) && ha_pedido) begin
                sel_q <= vencedor;
            end
            if (estado == CONCEDE) begin
                we_q   <= sel_we;
                meio_q <= sel_meio;
                erro_q <= sel_fora;
            end
        end
    end

    always_comb begin
        proximo     = estado;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        valido0     = 1'b0;
        valido1     = 1'b0;
        lido0       = 32'd0;
        lido1       = 32'd0;
        erro0       = 1'b0;
        erro1       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_end     = '0;
        mem_dado    = 32'd0;
        mem_mascara = 2'b00;
        resultado   = 32'd0;

        case (estado)
            OCIOSO: begin
                if (ha_pedido) begin
                    proximo = CONCEDE;
                end
            end

            CONCEDE: begin
                gnt0        = ~sel_q;
                gnt1        = sel_q;
                // An out-of-range address is still granted but never
                // touches the memory.
                mem_en      = ~sel_fora;
                mem_we      = sel_we;
                mem_end     = sel_end[LARGURA_END+1:2];
                mem_dado    = sel_dado;
                mem_mascara = mascara_de(tamanho_t'(sel_meio));
                proximo     = RESPONDE;
            end

            RESPONDE: begin
                if (!erro_q && !we_q) begin
                    if (tamanho_t'(meio_q) == TAM_MEIA) begin
                        resultado = estende_meia(mem_lido);
                    end else begin
                        resultado = mem_lido;
                    end
                end
                if (sel_q) begin
                    valido1 = 1'b1;
                    lido1   = resultado;
                    erro1   = erro_q;
                end else begin
                    valido0 = 1'b1;
                    lido0   = resultado;
                    erro0   = erro_q;
                end
                // Back-to-back: a pending request skips OCIOSO entirely.
                proximo = ha_pedido ? CONCEDE : OCIOSO;
            end

            default: begin
                proximo = OCIOSO;
            end
        endcase
    end

endmodule
